spi_mnrch_arb: RTL
==================

# spi_mnrch_arb

Round-robin arbiter that shares one SPI monarch (16-bit, mode-3, `wrt`/`done` handshake) between `NUM_REQ` on-chip requesters, such as the inertial-sensor and A2D front ends. It accepts one 16-bit command at a time and launches it on the monarch with a single-cycle `wrt`. It waits for the monarch's `done` to rise, then returns the 16-bit read word to the granted requester only. The block sits between the client blocks and the SPI monarch instance; it never touches SS_n, SCLK, MOSI or MISO.

## Interface
- `NUM_REQ`, default 4: number of requesters. Legal range is 2..8.
- `TIMEOUT_CYC`, default 1024: watchdog limit in clk cycles. It is used only when `SPI_ARB_TIMEOUT_EN` is defined.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `req`  in  NUM_REQ  level request per requester. It must stay high, with its data stable, until its `gnt` bit pulses.
- `req_data`  in  16*NUM_REQ  command words. Requester i uses bits [16i+15:16i].
- `gnt`  out  NUM_REQ  one-hot, one-cycle pulse: the command has been accepted.
- `rsp_vld`  out  NUM_REQ  one-hot, one-cycle pulse: `rsp_data` is valid for that requester.
- `rsp_data`  out  16  read word returned by the monarch. It holds its value until the next response.
- `err`  out  1  one-cycle pulse coincident with `rsp_vld` when the transaction timed out.
- `busy`  out  1  high in every state except IDLE.
- `wrt`  out  1  one-cycle launch strobe to the monarch.
- `wt_data`  out  16  command word to the monarch. It is held stable from `wrt` until completion.
- `done`  in  1  monarch done level. It is set at the end of a transfer and cleared by the next `wrt`.
- `rd_data`  in  16  monarch shift register contents. Valid when `done` rises.

## Operation
- States and transitions:
  - IDLE → LAUNCH: any `req` bit is high.
  - LAUNCH → WAIT: unconditional.
  - WAIT → RESP: `done` rises, or on timeout.
  - RESP → IDLE: unconditional.
  - Illegal encoding → IDLE.
- IDLE:
  - Samples `req` and picks the winner by searching upward from pointer `ptr`, wrapping from NUM_REQ-1 to 0.
  - Latches the winner index into `sel` and its `req_data` word into `wt_data`.
  - `req` is ignored in all other states.
- LAUNCH:
  - `gnt[sel]`=1 and `wrt`=1 for exactly this cycle.
  - `ptr` is updated to (sel+1) mod NUM_REQ.
- WAIT:
  - A `done_q` register tracks `done`.
  - Completion is `done & ~done_q`. A `done` level left high from the previous transfer is not a completion.
- RESP:
  - `rsp_vld[sel]`=1 for exactly this cycle.
  - `rsp_data` is loaded from `rd_data` on the WAIT→RESP edge.
- Requester rule: deassert `req` no later than the cycle after `gnt`. A `req` still high back in IDLE is treated as a new request.
- Fairness: a requester that holds `req` continuously is granted at least once in every NUM_REQ grants.
- Reset values:
  - state = IDLE, `ptr` = 0, `sel` = 0, `done_q` = 0.
  - `wt_data` and `rsp_data` = 16'h0000.
  - `gnt`, `rsp_vld`, `wrt`, `err` and `busy` = 0.
- Reset mid-transaction: the block returns to IDLE immediately with no `rsp_vld`. The monarch may still finish its frame; because `done_q` resets to 0 and `done` is edge-qualified only in WAIT, that stale `done` is ignored.

## Timing
- `req` high at edge N while in IDLE: `gnt` and `wrt` are high during cycle N+1.
- `done` rises at cycle M: `rsp_vld` and `rsp_data` are valid in cycle M+1, and the block is back in IDLE at M+2.
- Minimum spacing between successive `wrt` pulses is (transfer length + 4) cycles.
- The arbiter adds no overhead inside the SPI frame.
- All outputs are registered or decoded directly from the state register.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT_CYC)+1 clears in LAUNCH and increments in WAIT.
  - When it reaches TIMEOUT_CYC with no `done` rise, the block goes to RESP with `rsp_data`=16'h0000 and `err`=1 alongside `rsp_vld[sel]`.
  - The `ptr` update is unaffected.
- `SPI_ARB_TIMEOUT_EN` undefined:
  - No counter exists and WAIT is left only on a `done` rise.
  - `err` is tied to 0.

## Test plan
- Single request: after reset, `req`=4'b0100 with data 16'hA5C3 → `gnt`=4'b0100 and `wrt` one cycle later, `wt_data`=16'hA5C3. Monarch model returns 16'h3C5A → `rsp_vld`=4'b0100, `rsp_data`=16'h3C5A, exactly one pulse each.
- Round-robin: `req`=4'b1111 held continuously → grant order 0,1,2,3,0. No requester is granted twice before all four have been granted.
- Wrap/pointer: grant requester 3, then `req`=4'b1001 → requester 0 wins. Grant requester 0, then `req`=4'b1001 → requester 3 wins.
- Stale done: `done` held high from the previous transfer while entering WAIT → no `rsp_vld` until `done` falls and rises again.
- Reset mid-WAIT: assert `rst_n`=0 for 2 cycles, then release → all outputs at reset values and `ptr`=0. A later monarch `done` rise produces no `rsp_vld`.
- Timeout (`SPI_ARB_TIMEOUT_EN`, TIMEOUT_CYC=64): `done` never rises → `rsp_vld[sel]` and `err` pulse exactly 65 cycles after `wrt`, with `rsp_data`=16'h0000. The next request is then granted normally.

Source files
------------

// File: rtl/spi_mnrch_arb.sv
// rtl/spi_mnrch_arb.sv - round-robin arbiter sharing one SPI monarch among NUM_REQ requesters
// Optional watchdog: define SPI_ARB_TIMEOUT_EN.
module spi_mnrch_arb #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_vld,
  output logic [15:0]            rsp_data,
  output logic                   err,
  output logic                   busy,
  output logic                   wrt,
  output logic [15:0]            wt_data,
  input  logic                   done,
  input  logic [15:0]            rd_data
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW1   = SEL_W + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("spi_mnrch_arb: illegal NUM_REQ or TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [15:0]        wt_data_q, wt_data_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  logic               done_q;
  logic               done_rise;
  logic [SEL_W-1:0]   win;
  logic               found;
  logic [NUM_REQ-1:0] sel_oh;

  // A done level left over from the previous frame must not count as completion.
  assign done_rise = done & ~done_q;
  assign sel_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_q;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    logic [SW1-1:0] sum;
    win   = ptr_q;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + SW1'(i);
      if (sum >= SW1'(NUM_REQ)) sum = sum - SW1'(NUM_REQ);
      if (!found && req[sum[SEL_W-1:0]]) begin
        win   = sum[SEL_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    wt_data_d  = wt_data_q;
    rsp_data_d = rsp_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = LAUNCH;
          sel_d     = win;
          wt_data_d = req_data[16*win +: 16];
        end
      end
      LAUNCH: begin
        state_d = WAIT;
        ptr_d   = (sel_q == SEL_W'(NUM_REQ-1)) ? '0 : sel_q + 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (done_rise) begin
          state_d    = RESP;
          rsp_data_d = rd_data;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
          state_d    = RESP;
          rsp_data_d = 16'h0000;
          err_d      = 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      wt_data_q  <= 16'h0000;
      rsp_data_q <= 16'h0000;
      done_q     <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      wt_data_q  <= wt_data_d;
      rsp_data_q <= rsp_data_d;
      done_q     <= done;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign gnt      = (state_q == LAUNCH) ? sel_oh : '0;
  assign wrt      = (state_q == LAUNCH);
  assign rsp_vld  = (state_q == RESP) ? sel_oh : '0;
  assign busy     = (state_q != IDLE);
  assign wt_data  = wt_data_q;
  assign rsp_data = rsp_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
